// File: rtl/pwm_pkg.sv
// Shared PWM definitions: bus widths, scheduler state encoding and error counter width.
// Reused by the PWM config scheduler, config register block and controller.
package pwm_pkg;

  localparam int unsigned PWM_CH_W  = 8;
  localparam int unsigned PWM_CNT_W = 28;
  localparam int unsigned ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StGap   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/pwm_cfg_check.sv
// Combinational legality check of a single PWM config request.
// Flags an unknown channel, or an enabled request whose duty cycle cannot be produced.
module pwm_cfg_check
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_NUM = 1
) (
  input  logic [PWM_CH_W-1:0]  channel,
  input  logic                 en,
  input  logic [PWM_CNT_W-1:0] period,
  input  logic [PWM_CNT_W-1:0] hlevel,
  output logic                 invalid
);

  logic ch_bad;
  logic shape_bad;

  always_comb begin
    ch_bad    = (32'(channel) >= PWM_NUM);
    // A disabled channel ignores period/hlevel, so only the channel is checked.
    shape_bad = en && ((period == '0) || (hlevel > period));
    invalid   = ch_bad || shape_bad;
  end

endmodule

// File: rtl/pwm_cfg_sched.sv
// Two-requester round-robin scheduler onto the shared PWM config bus.
// Each legal request produces one config pulse followed by a fixed idle gap.
module pwm_cfg_sched
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_NUM    = 1,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 req0_vld,
  output logic                 req0_rdy,
  input  logic [PWM_CH_W-1:0]  req0_channel,
  input  logic                 req0_en,
  input  logic [PWM_CNT_W-1:0] req0_period,
  input  logic [PWM_CNT_W-1:0] req0_hlevel,

  input  logic                 req1_vld,
  output logic                 req1_rdy,
  input  logic [PWM_CH_W-1:0]  req1_channel,
  input  logic                 req1_en,
  input  logic [PWM_CNT_W-1:0] req1_period,
  input  logic [PWM_CNT_W-1:0] req1_hlevel,

  output logic                 pwm_config_vld,
  output logic [PWM_CH_W-1:0]  pwm_config_channel,
  output logic                 pwm_en,
  output logic [PWM_CNT_W-1:0] pwm_period,
  output logic [PWM_CNT_W-1:0] pwm_hlevel,

  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sched_state_e state_q, state_d;
  logic         ptr_q, ptr_d;
  logic [GapW-1:0] gap_q, gap_d;

  logic                 gnt0, gnt1, accept, invalid, issue;
  logic [PWM_CH_W-1:0]  sel_channel;
  logic                 sel_en;
  logic [PWM_CNT_W-1:0] sel_period, sel_hlevel;

  logic                 cfg_vld_q;
  logic [PWM_CH_W-1:0]  cfg_channel_q;
  logic                 cfg_en_q;
  logic [PWM_CNT_W-1:0] cfg_period_q, cfg_hlevel_q;
  logic                 err_pulse_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // ptr_q selects requester 1 when both are valid.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst && (state_q == StIdle)) begin
      gnt0 = req0_vld && (!req1_vld || !ptr_q);
      gnt1 = req1_vld && (!req0_vld || ptr_q);
    end
    accept      = gnt0 || gnt1;
    sel_channel = gnt1 ? req1_channel : req0_channel;
    sel_en      = gnt1 ? req1_en      : req0_en;
    sel_period  = gnt1 ? req1_period  : req0_period;
    sel_hlevel  = gnt1 ? req1_hlevel  : req0_hlevel;
  end

  assign req0_rdy = gnt0;
  assign req1_rdy = gnt1;

  pwm_cfg_check #(
    .PWM_NUM (PWM_NUM)
  ) u_check (
    .channel (sel_channel),
    .en      (sel_en),
    .period  (sel_period),
    .hlevel  (sel_hlevel),
    .invalid (invalid)
  );

  assign issue = accept && !invalid;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    if (accept) begin
      ptr_d = gnt0;
    end
    case (state_q)
      StIdle: begin
        // Rejected requests stay in idle so the next request can be taken at once.
        if (issue) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (GAP_CYCLES == 0) begin
          state_d = StIdle;
        end else begin
          state_d = StGap;
          gap_d   = GapLoad;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      ptr_q         <= 1'b0;
      gap_q         <= '0;
      cfg_vld_q     <= 1'b0;
      cfg_channel_q <= '0;
      cfg_en_q      <= 1'b0;
      cfg_period_q  <= '0;
      cfg_hlevel_q  <= '0;
      err_pulse_q   <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gap_q       <= gap_d;
      cfg_vld_q   <= issue;
      err_pulse_q <= accept && invalid;
      // Bus fields only move on an issued request so they hold the last config.
      if (issue) begin
        cfg_channel_q <= sel_channel;
        cfg_en_q      <= sel_en;
        cfg_period_q  <= sel_period;
        cfg_hlevel_q  <= sel_hlevel;
      end
      if (accept && invalid && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign pwm_config_vld     = cfg_vld_q;
  assign pwm_config_channel = cfg_channel_q;
  assign pwm_en             = cfg_en_q;
  assign pwm_period         = cfg_period_q;
  assign pwm_hlevel         = cfg_hlevel_q;
  assign err_pulse          = err_pulse_q;
  assign err_cnt            = err_cnt_q;

endmodule
